// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// The controller (master) reads instruction fields and status flags and drives
// every mux select, enable and memory request. The datapath (slave) does the reverse.
interface mc_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       alu_flag;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, alu_zero, alu_flag, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
               mem_to_reg, illegal, state
    );

    modport slave (
        output opcode, funct, alu_zero, alu_flag, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
               mem_to_reg, illegal, state
    );
endinterface

// File: rtl/mc_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch, decode,
// execute, memory and write-back, and stalls on the memory ready handshake.
// Outputs are decoded from the registered state; FETCH's IR/PC load, BRANCH's
// PC load and the illegal flag additionally look at the current inputs.
module mc_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic          clk,
    input logic          rst_n,
    mc_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        ALU_WB   = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [4:0] ALU_ZERO = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_NOR  = 5'd6;
    localparam logic [4:0] ALU_BGTZ = 5'd7;

    state_t     cur;
    logic [4:0] r_op;
    logic       funct_ok;
    logic       opcode_ok;

    assign opcode_ok = bus.opcode inside {OP_RTYPE, OP_J, OP_BEQ, OP_BGTZ,
                                          OP_ADDI, OP_LW, OP_SW};

    // R-type funct field to ALU opcode; unsupported functs map to ALU_ZERO.
    always_comb begin
        r_op     = ALU_ZERO;
        funct_ok = 1'b1;
        case (bus.funct)
            6'h20:   r_op = ALU_ADD;
            6'h22:   r_op = ALU_SUB;
            6'h24:   r_op = ALU_AND;
            6'h25:   r_op = ALU_OR;
            6'h26:   r_op = ALU_XOR;
            6'h27:   r_op = ALU_NOR;
            default: funct_ok = 1'b0;
        endcase
    end

    // State register and next-state sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= state_t'(RESET_STATE);
        end else begin
            case (cur)
                FETCH:    if (bus.mem_ready) cur <= DECODE;
                DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:       cur <= EXEC;
                        OP_LW, OP_SW:   cur <= MEM_ADDR;
                        OP_BEQ, OP_BGTZ: cur <= BRANCH;
                        OP_J:           cur <= JUMP;
                        OP_ADDI:        cur <= ADDI_EX;
                        default:        cur <= FETCH;
                    endcase
                end
                EXEC:     cur <= funct_ok ? ALU_WB : FETCH;
                ALU_WB:   cur <= FETCH;
                MEM_ADDR: cur <= (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   if (bus.mem_ready) cur <= MEM_WB;
                MEM_WB:   cur <= FETCH;
                MEM_WR:   if (bus.mem_ready) cur <= FETCH;
                BRANCH:   cur <= FETCH;
                JUMP:     cur <= FETCH;
                ADDI_EX:  cur <= ADDI_WB;
                ADDI_WB:  cur <= FETCH;
                default:  cur <= FETCH;
            endcase
        end
    end

    assign bus.state = cur;

    // Per-state datapath control decode; anything not set stays 0.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_op     = ALU_ZERO;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.illegal    = 1'b0;
        case (cur)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.alu_op    = ALU_ADD;
                // Held off while reset is asserted so an abandoned
                // instruction cannot load IR or PC.
                if (bus.mem_ready && rst_n) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end
            end
            DECODE: begin
                bus.alu_src_b = 2'd3;
                bus.alu_op    = ALU_ADD;
                bus.illegal   = !opcode_ok;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = r_op;
                bus.illegal   = !funct_ok;
            end
            ALU_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            MEM_ADDR, ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                bus.mem_we  = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = 2'd1;
                if (bus.opcode == OP_BEQ) begin
                    bus.alu_op   = ALU_SUB;
                    bus.pc_write = bus.alu_zero;
                end else begin
                    bus.alu_op   = ALU_BGTZ;
                    bus.pc_write = bus.alu_flag;
                end
            end
            JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'd2;
            end
            ADDI_WB: begin
                bus.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus randomized
// instructions, each scored at instruction level against a reference model.
module tb_mc_control;

    logic clk = 1'b0;
    logic rst_n;

    mc_control_if bus ();

    mc_control #(.RESET_STATE(4'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Observed per-instruction statistics.
    int unsigned s_cyc, s_irw, s_fpw, s_rw, s_we, s_st, s_bpw, s_ill;
    logic        s_rdst, s_m2r;
    logic [1:0]  s_bsrc;
    logic [4:0]  s_op;
    bit          s_done;
    int unsigned s_seq[$];

    // Expected per-instruction statistics.
    int unsigned e_cyc, e_rw, e_we, e_st, e_bpw, e_ill;
    logic        e_rdst, e_m2r;
    logic [1:0]  e_bsrc;
    logic [4:0]  e_op;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Instruction-level reference: cycle count, side effects and ALU use.
    task automatic predict(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic f, input int unsigned fw, input int unsigned dw);
        bit legal;
        e_cyc = 0; e_rw = 0; e_rdst = 0; e_m2r = 0; e_we = 0; e_st = 0;
        e_bpw = 0; e_bsrc = 2'd0; e_ill = 0; e_op = 5'd0;
        legal = 1'b1;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: e_op = 5'd1;
                    6'h22: e_op = 5'd2;
                    6'h24: e_op = 5'd3;
                    6'h25: e_op = 5'd4;
                    6'h26: e_op = 5'd5;
                    6'h27: e_op = 5'd6;
                    default: legal = 1'b0;
                endcase
                if (legal) begin e_cyc = 4 + fw; e_rw = 1; e_rdst = 1'b1; end
                else begin e_cyc = 3 + fw; e_ill = 1; end
            end
            6'h23: begin e_cyc = 5 + fw + dw; e_rw = 1; e_m2r = 1'b1; e_op = 5'd1; end
            6'h2b: begin e_cyc = 4 + fw + dw; e_we = 1 + dw; e_st = 1; e_op = 5'd1; end
            6'h04: begin e_cyc = 3 + fw; e_bpw = z; e_bsrc = 2'd1; e_op = 5'd2; end
            6'h07: begin e_cyc = 3 + fw; e_bpw = f; e_bsrc = 2'd1; e_op = 5'd7; end
            6'h02: begin e_cyc = 3 + fw; e_bpw = 1; e_bsrc = 2'd2; end
            6'h08: begin e_cyc = 4 + fw; e_rw = 1; e_op = 5'd1; end
            default: begin e_cyc = 2 + fw; e_ill = 1; end
        endcase
    endtask

    // Runs one instruction starting in FETCH; fw/dw are the ready-low cycles
    // inserted in the fetch and the data access. Ends just after the DUT is
    // back in FETCH, at posedge+1 with mem_ready low.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic f, input int unsigned fw, input int unsigned dw);
        int unsigned fleft, dleft;
        bit left_fetch;
        fleft = fw; dleft = dw; left_fetch = 1'b0; s_done = 1'b0;
        s_cyc = 0; s_irw = 0; s_fpw = 0; s_rw = 0; s_we = 0; s_st = 0;
        s_bpw = 0; s_ill = 0; s_rdst = 1'b0; s_m2r = 1'b0; s_bsrc = 2'd0; s_op = 5'd0;
        s_seq.delete();
        bus.opcode = op; bus.funct = fn; bus.alu_zero = z; bus.alu_flag = f;
        for (int c = 0; c < 40 && !s_done; c++) begin
            if (!bus.mem_req) bus.mem_ready = 1'b0;
            else if (bus.iord) begin
                if (dleft > 0) begin bus.mem_ready = 1'b0; dleft--; end
                else bus.mem_ready = 1'b1;
            end else begin
                if (fleft > 0) begin bus.mem_ready = 1'b0; fleft--; end
                else bus.mem_ready = 1'b1;
            end
            @(negedge clk);
            if (left_fetch && bus.state == 4'd0) begin
                s_done = 1'b1;
                bus.mem_ready = 1'b0;
            end else begin
                s_cyc++;
                s_seq.push_back(int'(bus.state));
                if (bus.state != 4'd0) left_fetch = 1'b1;
                if (bus.mem_req && !bus.mem_ready)
                    chk("wait_quiet", {29'd0, bus.ir_write, bus.pc_write, bus.reg_write}, 32'd0);
                if (bus.ir_write) s_irw++;
                if (bus.reg_write) begin s_rw++; s_rdst = bus.reg_dst; s_m2r = bus.mem_to_reg; end
                if (bus.mem_we) s_we++;
                if (bus.mem_req && bus.mem_we && bus.mem_ready) s_st++;
                if (bus.pc_write && bus.pc_src == 2'd0) s_fpw++;
                if (bus.pc_write && bus.pc_src != 2'd0) begin s_bpw++; s_bsrc = bus.pc_src; end
                if (bus.illegal) s_ill++;
                if (bus.alu_src_a) s_op = bus.alu_op;
            end
            @(posedge clk);
            #1;
        end
        chk("run_done", {31'd0, s_done}, 32'd1);
    endtask

    task automatic check_run(input string tag);
        chk({tag, ".cycles"}, s_cyc, e_cyc);
        chk({tag, ".ir_write"}, s_irw, 1);
        chk({tag, ".fetch_pc"}, s_fpw, 1);
        chk({tag, ".reg_write"}, s_rw, e_rw);
        if (e_rw != 0) begin
            chk({tag, ".reg_dst"}, {31'd0, s_rdst}, {31'd0, e_rdst});
            chk({tag, ".mem_to_reg"}, {31'd0, s_m2r}, {31'd0, e_m2r});
        end
        chk({tag, ".mem_we"}, s_we, e_we);
        chk({tag, ".stores"}, s_st, e_st);
        chk({tag, ".br_pc"}, s_bpw, e_bpw);
        if (e_bpw != 0) chk({tag, ".pc_src"}, {30'd0, s_bsrc}, {30'd0, e_bsrc});
        chk({tag, ".illegal"}, s_ill, e_ill);
        chk({tag, ".alu_op"}, {27'd0, s_op}, {27'd0, e_op});
    endtask

    task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input logic f, input int unsigned fw,
                            input int unsigned dw);
        predict(op, fn, z, f, fw, dw);
        run_instr(op, fn, z, f, fw, dw);
        check_run(tag);
    endtask

    initial begin
        int unsigned exp_r[4];
        int unsigned rd_cnt;
        exp_r = '{0, 1, 6, 7};

        rst_n = 1'b0;
        bus.opcode = 6'h00; bus.funct = 6'h00;
        bus.alu_zero = 1'b0; bus.alu_flag = 1'b0; bus.mem_ready = 1'b0;
        #3;
        chk("rst.state", {28'd0, bus.state}, 32'd0);
        chk("rst.mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("rst.alu_op", {27'd0, bus.alu_op}, 32'd1);
        chk("rst.alu_src_b", {30'd0, bus.alu_src_b}, 32'd1);
        chk("rst.quiet", {27'd0, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_we, bus.illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type sub: FETCH, DECODE, EXEC, ALU_WB.
        do_instr("sub", 6'h00, 6'h22, 1'b0, 1'b0, 0, 0);
        chk("sub.seq_len", s_seq.size(), 4);
        for (int i = 0; i < 4 && i < s_seq.size(); i++)
            chk("sub.seq", s_seq[i], exp_r[i]);

        // lw with two wait cycles on the data read.
        do_instr("lw_wait", 6'h23, 6'h00, 1'b0, 1'b0, 0, 2);
        rd_cnt = 0;
        foreach (s_seq[i]) if (s_seq[i] == 3) rd_cnt++;
        chk("lw_wait.mem_rd_cycles", rd_cnt, 3);

        do_instr("bgtz_t", 6'h07, 6'h00, 1'b0, 1'b1, 0, 0);
        do_instr("bgtz_nt", 6'h07, 6'h00, 1'b1, 1'b0, 0, 0);
        do_instr("beq_t", 6'h04, 6'h00, 1'b1, 1'b0, 0, 0);
        do_instr("j", 6'h02, 6'h00, 1'b0, 1'b0, 1, 0);
        do_instr("bad_op", 6'h3f, 6'h00, 1'b0, 1'b0, 0, 0);
        do_instr("bad_funct", 6'h00, 6'h00, 1'b0, 1'b0, 0, 0);
        do_instr("sw_wait", 6'h2b, 6'h00, 1'b0, 1'b0, 2, 1);

        // Reset asserted mid-wait in MEM_WR.
        bus.opcode = 6'h2b; bus.mem_ready = 1'b1;
        @(posedge clk); #1; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid.state", {28'd0, bus.state}, 32'd5);
        chk("mid.mem_we", {31'd0, bus.mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.state", {28'd0, bus.state}, 32'd0);
        chk("arst.mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("arst.mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("arst.alu_op", {27'd0, bus.alu_op}, 32'd1);
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        chk("arst.hold", {28'd0, bus.state}, 32'd0);
        chk("arst.no_load", {30'd0, bus.ir_write, bus.pc_write}, 32'd0);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized instruction mix.
        for (int i = 0; i < 40; i++) begin
            logic [5:0] op, fn;
            logic z, f;
            int unsigned pick, fw, dw;
            pick = $urandom_range(0, 8);
            case (pick)
                0, 1: op = 6'h00;
                2: op = 6'h23;
                3: op = 6'h2b;
                4: op = 6'h04;
                5: op = 6'h07;
                6: op = 6'h02;
                7: op = 6'h08;
                default: op = 6'h30 | 6'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 6))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h26;
                5: fn = 6'h27;
                default: fn = 6'($urandom);
            endcase
            z = 1'($urandom);
            f = 1'($urandom);
            fw = $urandom_range(0, 2);
            dw = $urandom_range(0, 2);
            do_instr("rand", op, fn, z, f, fw, dw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
